sha_in_packer: RTL

- AXI-Stream slave front end of the SHA-3 core; mirror of the digest serializer on the output side.
- Accepts DATA_WIDTH-bit message words and assembles them into one rate-sized block for the selected SHA-3 variant.
- Applies SHA-3 domain/pad10*1 padding on the final block and maps the block onto the 5x5x64 Keccak state layout.
- Holds each block until the permutation core acknowledges it.

---
 rtl/sha_in_packer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sha_in_packer.sv
// AXI-Stream slave that packs message words into one SHA-3 rate block, applies
// domain/pad10*1 padding on the last block and presents it in Keccak lane layout.
module sha_in_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_WORDS  = 1152 / DATA_WIDTH
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [DATA_WIDTH-1:0]  S_TDATA,
  input  logic                   S_TVALID,
  output logic                   S_TREADY,
  input  logic                   S_TLAST,
  input  logic [1:0]             S_TUSER,
  output logic [4:0][4:0][63:0]  Dout,
  output logic                   Block_valid,
  output logic                   Block_last,
  output logic [1:0]             Mode_out,
  input  logic                   Block_ack
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int BPW   = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1151:0]    blk_q, blk_d;
  logic [1:0]       mode_q, mode_d;
  logic             last_q, last_d;
  logic             pend_q, pend_d;

  logic [7:0]            rate_b;
  logic [CNT_W-1:0]      blk_words;
  logic [7:0]            pad_idx;
  logic [DATA_WIDTH-1:0] swapped;
  logic                  hs;

  function automatic logic [7:0] rate_bytes(input logic [1:0] m);
    case (m)
      2'd0:    rate_bytes = 8'd144;
      2'd1:    rate_bytes = 8'd136;
      2'd2:    rate_bytes = 8'd104;
      default: rate_bytes = 8'd72;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] words_per_block(input logic [1:0] m);
    case (m)
      2'd0:    words_per_block = CNT_W'(1152 / DATA_WIDTH);
      2'd1:    words_per_block = CNT_W'(1088 / DATA_WIDTH);
      2'd2:    words_per_block = CNT_W'(832 / DATA_WIDTH);
      default: words_per_block = CNT_W'(576 / DATA_WIDTH);
    endcase
  endfunction

  assign rate_b    = rate_bytes(mode_q);
  assign blk_words = words_per_block(mode_q);
  assign pad_idx   = 8'(cnt_q) * 8'(BPW);

  assign S_TREADY    = ARESETN && ((state_q == S_IDLE) || (state_q == S_FILL));
  assign Block_valid = (state_q == S_HOLD);
  assign Block_last  = (state_q == S_HOLD) && last_q;
  assign Mode_out    = mode_q;

  // Stream bytes arrive big-endian within each halfword; swap to message byte order.
  always_comb begin
    swapped = '0;
    for (int h = 0; h < DATA_WIDTH / 16; h++) begin
      swapped[16*h +: 16] = {S_TDATA[16*h +: 8], S_TDATA[16*h+8 +: 8]};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    mode_d  = mode_q;
    last_d  = last_q;
    pend_d  = pend_q;
    hs      = S_TVALID && S_TREADY;

    if (hs) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        if (cnt_q == CNT_W'(k)) blk_d[k*DATA_WIDTH +: DATA_WIDTH] = swapped;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (hs) begin
          mode_d  = S_TUSER;
          cnt_d   = cnt_q + 1'b1;
          last_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = S_TLAST ? S_PAD : S_FILL;
        end
      end
      S_FILL: begin
        if (hs) begin
          if (cnt_q == blk_words - 1'b1) begin
            // Full block: a coincident TLAST defers padding to an extra block.
            state_d = S_HOLD;
            last_d  = 1'b0;
            pend_d  = S_TLAST;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (S_TLAST) state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        for (int i = 0; i < 144; i++) begin
          if (pad_idx == 8'(i))              blk_d[8*i +: 8] = 8'h06;
          if ((rate_b - 8'd1) == 8'(i))      blk_d[8*i + 7]  = 1'b1;
        end
        last_d  = 1'b1;
        state_d = S_HOLD;
      end
      default: begin
        if (Block_ack) begin
          blk_d = '0;
          cnt_d = '0;
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = S_PAD;
          end else if (last_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FILL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      mode_q  <= 2'd0;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  // Block lane L lands on Dout[(24-L)%5][(24-L)/5]; capacity lanes 18..24 stay zero.
  always_comb begin
    Dout = '0;
    for (int l = 0; l < 18; l++) begin
      Dout[(24-l)%5][(24-l)/5] = blk_q[64*l +: 64];
    end
  end

endmodule
